// File: rtl/ex_if.sv
// Bundle between decode/fetch/memory and the execute stage.
// Latency: n/a (wires only).
// Backpressure: stall_out tells upstream to hold ID/EX; mem_stall freezes EX.
interface ex_if #(parameter int XLEN = 32);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1_idx;
    logic [4:0]      id_rs2_idx;
    logic [4:0]      id_rd_idx;
    logic [3:0]      id_alu_control;
    logic            id_inv_branch;
    logic            id_is_branch;
    logic            id_is_jal;
    logic            id_is_jalr;
    logic            id_src_a_pc;
    logic            id_src_b_imm;
    logic            id_reg_we;
    logic            id_mem_re;
    logic            id_mem_we;
    logic            mem_stall;
    logic            wb_reg_we;
    logic [4:0]      wb_rd_idx;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd_idx;
    logic            ex_reg_we;
    logic            ex_mem_re;
    logic            ex_mem_we;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            load_use_stall;
    logic            stall_out;

    // Upstream/environment side: drives instruction and writeback info.
    modport master (
        output id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
               id_rs1_idx, id_rs2_idx, id_rd_idx, id_alu_control, id_inv_branch,
               id_is_branch, id_is_jal, id_is_jalr, id_src_a_pc, id_src_b_imm,
               id_reg_we, id_mem_re, id_mem_we, mem_stall, wb_reg_we, wb_rd_idx, wb_data,
        input  ex_valid, ex_pc, ex_result, ex_store_data, ex_rd_idx, ex_reg_we,
               ex_mem_re, ex_mem_we, redirect_valid, redirect_pc, load_use_stall, stall_out
    );

    // Execute stage side.
    modport slave (
        input  id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
               id_rs1_idx, id_rs2_idx, id_rd_idx, id_alu_control, id_inv_branch,
               id_is_branch, id_is_jal, id_is_jalr, id_src_a_pc, id_src_b_imm,
               id_reg_we, id_mem_re, id_mem_we, mem_stall, wb_reg_we, wb_rd_idx, wb_data,
        output ex_valid, ex_pc, ex_result, ex_store_data, ex_rd_idx, ex_reg_we,
               ex_mem_re, ex_mem_we, redirect_valid, redirect_pc, load_use_stall, stall_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch/jump resolution, load-use detect, EX/MEM reg.
// Latency: 1 cycle to EX/MEM and to the registered redirect.
// Backpressure: mem_stall freezes everything; load-use inserts a bubble and raises stall_out.
module ex_stage #(
    parameter int XLEN         = 32,
    parameter int SHADOW_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_SLL  = 4'd2;
    localparam logic [3:0] ALUOP_SLT  = 4'd3;
    localparam logic [3:0] ALUOP_SLTU = 4'd4;
    localparam logic [3:0] ALUOP_XOR  = 4'd5;
    localparam logic [3:0] ALUOP_SRL  = 4'd6;
    localparam logic [3:0] ALUOP_SRA  = 4'd7;
    localparam logic [3:0] ALUOP_OR   = 4'd8;
    localparam logic [3:0] ALUOP_AND  = 4'd9;

    localparam int CW = $clog2(SHADOW_DEPTH + 1);

    typedef enum logic {ST_RUN, ST_SHADOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            ex_valid_q, ex_reg_we_q, ex_mem_re_q, ex_mem_we_q;
    logic [XLEN-1:0] ex_pc_q, ex_result_q, ex_store_q;
    logic [4:0]      ex_rd_q;
    logic            redir_vld_q;
    logic [XLEN-1:0] redir_pc_q;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_out, result, target;
    logic            killing, eff_valid, load_use, accept, taken, use_rs1, use_rs2, advance;

    // Forwarding: EX/MEM result (non-load) beats WB, WB beats the register file; x0 never forwarded.
    always_comb begin
        fwd_rs1 = bus.id_rs1_val;
        if (bus.id_rs1_idx != 5'd0) begin
            if (ex_valid_q && ex_reg_we_q && !ex_mem_re_q && ex_rd_q == bus.id_rs1_idx)
                fwd_rs1 = ex_result_q;
            else if (bus.wb_reg_we && bus.wb_rd_idx == bus.id_rs1_idx)
                fwd_rs1 = bus.wb_data;
        end
        fwd_rs2 = bus.id_rs2_val;
        if (bus.id_rs2_idx != 5'd0) begin
            if (ex_valid_q && ex_reg_we_q && !ex_mem_re_q && ex_rd_q == bus.id_rs2_idx)
                fwd_rs2 = ex_result_q;
            else if (bus.wb_reg_we && bus.wb_rd_idx == bus.id_rs2_idx)
                fwd_rs2 = bus.wb_data;
        end
    end

    assign op_a = bus.id_src_a_pc  ? bus.id_pc  : fwd_rs1;
    assign op_b = bus.id_src_b_imm ? bus.id_imm : fwd_rs2;

    // ALU; unknown codes produce zero.
    always_comb begin
        alu_out = '0;
        case (bus.id_alu_control)
            ALUOP_ADD:  alu_out = op_a + op_b;
            ALUOP_SUB:  alu_out = op_a - op_b;
            ALUOP_SLL:  alu_out = op_a << op_b[4:0];
            ALUOP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALUOP_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALUOP_XOR:  alu_out = op_a ^ op_b;
            ALUOP_SRL:  alu_out = op_a >> op_b[4:0];
            ALUOP_SRA:  alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALUOP_OR:   alu_out = op_a | op_b;
            ALUOP_AND:  alu_out = op_a & op_b;
            default:    alu_out = '0;
        endcase
    end

    // Control-flow resolution: branches compare via the ALU result, jumps always go.
    always_comb begin
        taken  = (bus.id_is_branch && ((alu_out == '0) ^ bus.id_inv_branch))
                 || bus.id_is_jal || bus.id_is_jalr;
        target = bus.id_pc + bus.id_imm;
        if (bus.id_is_jal)
            target = alu_out;
        else if (bus.id_is_jalr)
            target = {alu_out[XLEN-1:1], 1'b0};
        result = (bus.id_is_jal || bus.id_is_jalr) ? bus.id_pc + XLEN'(4) : alu_out;
    end

    assign killing   = (state_q == ST_SHADOW);
    assign eff_valid = bus.id_valid && !killing;
    assign use_rs1   = !bus.id_src_a_pc;
    assign use_rs2   = !bus.id_src_b_imm || bus.id_mem_we || bus.id_is_branch;
    assign load_use  = eff_valid && ex_valid_q && ex_mem_re_q && (ex_rd_q != 5'd0) &&
                       ((use_rs1 && bus.id_rs1_idx == ex_rd_q) ||
                        (use_rs2 && bus.id_rs2_idx == ex_rd_q));
    assign advance   = !bus.mem_stall && !load_use;
    assign accept    = eff_valid && !load_use;

    // EX/MEM pipeline register; bubbles and killed slots clear valid and all enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_reg_we_q <= 1'b0;
            ex_mem_re_q <= 1'b0;
            ex_mem_we_q <= 1'b0;
            ex_pc_q     <= '0;
            ex_result_q <= '0;
            ex_store_q  <= '0;
            ex_rd_q     <= '0;
        end else if (!bus.mem_stall) begin
            ex_valid_q  <= accept;
            ex_reg_we_q <= accept && bus.id_reg_we;
            ex_mem_re_q <= accept && bus.id_mem_re;
            ex_mem_we_q <= accept && bus.id_mem_we;
            ex_pc_q     <= bus.id_pc;
            ex_result_q <= result;
            ex_store_q  <= fwd_rs2;
            ex_rd_q     <= bus.id_rd_idx;
        end
    end

    // Redirect register: one advancing cycle of valid per taken control transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else if (!bus.mem_stall) begin
            redir_vld_q <= accept && taken;
            redir_pc_q  <= target;
        end
    end

    // FSM state and kill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter SHADOW on an issued redirect, leave once the last wrong-path slot is killed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (advance && eff_valid && taken) begin
                    state_d = ST_SHADOW;
                    cnt_d   = CW'(SHADOW_DEPTH);
                end
            end
            ST_SHADOW: begin
                if (advance) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_d == '0)
                        state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_pc          = ex_pc_q;
    assign bus.ex_result      = ex_result_q;
    assign bus.ex_store_data  = ex_store_q;
    assign bus.ex_rd_idx      = ex_rd_q;
    assign bus.ex_reg_we      = ex_reg_we_q;
    assign bus.ex_mem_re      = ex_mem_re_q;
    assign bus.ex_mem_we      = ex_mem_we_q;
    assign bus.redirect_valid = redir_vld_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.load_use_stall = load_use;
    assign bus.stall_out      = bus.mem_stall || load_use;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed program plus random traffic against a reference model.
// Latency: model predicts the EX/MEM/redirect state one clock after each input set.
// Backpressure: mem_stall and load-use are modelled as hold / bubble cycles.
module tb_ex_stage;
    localparam int SD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    ex_if #(.XLEN(32)) bus ();
    ex_stage #(.XLEN(32), .SHADOW_DEPTH(SD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state: what the EX/MEM and redirect registers should hold.
    bit          m_valid, m_we, m_re, m_mwe, m_rv;
    logic [31:0] m_pc, m_res, m_st, m_rpc;
    logic [4:0]  m_rd;
    int          m_kill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_re = 0; m_mwe = 0; m_rv = 0;
        m_pc = 0; m_res = 0; m_st = 0; m_rpc = 0; m_rd = 0; m_kill = 0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (m_valid && m_we && !m_re && m_rd == idx) return m_res;
        if (bus.wb_reg_we && bus.wb_rd_idx == idx) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int unsigned sh;
        sh = b % 32;
        case (op)
            0: return a + b;
            1: return a + (~b) + 1;
            2: return a * (32'd1 << sh);
            3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a / (32'd1 << sh);
            7: begin ext = {{32{a[31]}}, a} >> sh; return ext[31:0]; end
            8: return a | b;
            9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_regs();
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
        chk("ex_reg_we", {31'd0, bus.ex_reg_we}, {31'd0, m_we});
        chk("ex_mem_re", {31'd0, bus.ex_mem_re}, {31'd0, m_re});
        chk("ex_mem_we", {31'd0, bus.ex_mem_we}, {31'd0, m_mwe});
        chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_rv});
        if (m_valid) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_result", bus.ex_result, m_res);
            chk("ex_store_data", bus.ex_store_data, m_st);
            chk("ex_rd_idx", {27'd0, bus.ex_rd_idx}, {27'd0, m_rd});
        end
        if (m_rv) chk("redirect_pc", bus.redirect_pc, m_rpc);
    endtask

    // One clock: check combinational stalls, clock, then check registered state against the model.
    task automatic step();
        bit eff, lus, tk;
        logic [31:0] f1, f2, a, b, r, tgt;
        eff = bus.id_valid && (m_kill == 0);
        f1 = fwd(bus.id_rs1_idx, bus.id_rs1_val);
        f2 = fwd(bus.id_rs2_idx, bus.id_rs2_val);
        a = bus.id_src_a_pc ? bus.id_pc : f1;
        b = bus.id_src_b_imm ? bus.id_imm : f2;
        r = alu(bus.id_alu_control, a, b);
        tk = (bus.id_is_branch && ((r == 0) != bus.id_inv_branch)) || bus.id_is_jal || bus.id_is_jalr;
        if (bus.id_is_jal) tgt = r;
        else if (bus.id_is_jalr) tgt = r & 32'hFFFF_FFFE;
        else tgt = bus.id_pc + bus.id_imm;
        lus = eff && m_valid && m_re && m_rd != 0 &&
              ((!bus.id_src_a_pc && bus.id_rs1_idx == m_rd) ||
               ((!bus.id_src_b_imm || bus.id_mem_we || bus.id_is_branch) && bus.id_rs2_idx == m_rd));
        #1;
        chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, lus});
        chk("stall_out", {31'd0, bus.stall_out}, {31'd0, lus || bus.mem_stall});
        @(posedge clk);
        #1;
        if (!bus.mem_stall) begin
            if (lus || m_kill > 0) begin
                if (!lus) m_kill--;
                m_valid = 0; m_we = 0; m_re = 0; m_mwe = 0; m_rv = 0;
            end else begin
                m_valid = eff; m_we = eff && bus.id_reg_we; m_re = eff && bus.id_mem_re;
                m_mwe = eff && bus.id_mem_we;
                m_pc = bus.id_pc; m_st = f2; m_rd = bus.id_rd_idx;
                m_res = (bus.id_is_jal || bus.id_is_jalr) ? bus.id_pc + 4 : r;
                m_rv = eff && tk; m_rpc = tgt;
                if (m_rv) m_kill = SD;
            end
        end
        check_regs();
    endtask

    task automatic instr(input logic [31:0] pc, v1, v2, imm, input logic [4:0] i1, i2, rd,
                         input logic [3:0] op, input bit inv, br, jal, jalr, sa, sb, we, re, mwe);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1_val = v1; bus.id_rs2_val = v2;
        bus.id_imm = imm; bus.id_rs1_idx = i1; bus.id_rs2_idx = i2; bus.id_rd_idx = rd;
        bus.id_alu_control = op; bus.id_inv_branch = inv; bus.id_is_branch = br;
        bus.id_is_jal = jal; bus.id_is_jalr = jalr; bus.id_src_a_pc = sa; bus.id_src_b_imm = sb;
        bus.id_reg_we = we; bus.id_mem_re = re; bus.id_mem_we = mwe;
    endtask

    task automatic check_all_zero();
        chk("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst enables", {29'd0, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we}, 32'd0);
        chk("rst redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst ex_pc", bus.ex_pc, 32'd0);
        chk("rst ex_result", bus.ex_result, 32'd0);
        chk("rst ex_store_data", bus.ex_store_data, 32'd0);
        chk("rst ex_rd_idx", {27'd0, bus.ex_rd_idx}, 32'd0);
        chk("rst redirect_pc", bus.redirect_pc, 32'd0);
    endtask

    initial begin
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.id_valid = 0; bus.mem_stall = 0;
        bus.wb_reg_we = 0; bus.wb_rd_idx = 0; bus.wb_data = 0;
        model_reset();
        #2;
        check_all_zero();
        @(posedge clk); #1;
        rst = 0;

        // Plain ALU ops.
        instr(32'h0, 5, 7, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("add 5+7", bus.ex_result, 32'd12);
        instr(32'h4, 32'h8000_0000, 0, 4, 1, 0, 4, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(); chk("sra", bus.ex_result, 32'hF800_0000);

        // EX/MEM and WB forwarding.
        instr(32'h8, 1, 2, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step();
        instr(32'hC, 0, 0, 0, 3, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("exmem fwd", bus.ex_result, 32'd6);
        bus.wb_reg_we = 1; bus.wb_rd_idx = 6; bus.wb_data = 9;
        instr(32'h10, 0, 0, 0, 6, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("wb fwd", bus.ex_result, 32'd9);
        bus.wb_reg_we = 0;

        // Load-use: one bubble, then WB-forwarded operand.
        instr(32'h14, 32'h1000, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        step();
        instr(32'h18, 0, 0, 0, 5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("load-use bubble", {31'd0, bus.ex_valid}, 32'd0);
        bus.wb_reg_we = 1; bus.wb_rd_idx = 5; bus.wb_data = 32'h55;
        step(); chk("after load-use", bus.ex_result, 32'h55);
        bus.wb_reg_we = 0;

        // Branches: BNE not taken, BNE taken with two killed slots, BGE -1 vs 1.
        instr(32'h100, 3, 3, 32'h20, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(); chk("bne equal", {31'd0, bus.redirect_valid}, 32'd0);
        instr(32'h100, 3, 4, 32'h20, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(); chk("bne taken", {31'd0, bus.redirect_valid}, 32'd1);
        chk("bne target", bus.redirect_pc, 32'h120);
        instr(32'h104, 1, 1, 0, 1, 2, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("shadow kill 1", {31'd0, bus.ex_valid}, 32'd0);
        step(); chk("shadow kill 2", {31'd0, bus.ex_valid}, 32'd0);
        step(); chk("after shadow", {31'd0, bus.ex_valid}, 32'd1);
        instr(32'h120, 32'hFFFF_FFFF, 1, 32'h10, 1, 2, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(); chk("bge -1,1", {31'd0, bus.redirect_valid}, 32'd0);

        // JALR, then mem_stall hold over the redirect, then async reset mid-shadow.
        instr(32'h40, 32'h201, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        step(); chk("jalr target", bus.redirect_pc, 32'h200);
        chk("jalr link", bus.ex_result, 32'h44);
        bus.mem_stall = 1;
        instr(32'h44, 9, 9, 0, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
            chk("stall redirect_pc", bus.redirect_pc, 32'h200);
            chk("stall ex_result", bus.ex_result, 32'h44);
        end
        #2 rst = 1;
        #1 check_all_zero();
        model_reset();
        bus.mem_stall = 0;
        @(posedge clk); #1;
        rst = 0;
        instr(32'h200, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); chk("post-reset accept", {31'd0, bus.ex_valid}, 32'd1);

        // Random traffic; small register indices to provoke hazards and forwarding.
        for (int n = 0; n < 600; n++) begin
            int cls;
            logic [31:0] v2;
            cls = $urandom_range(0, 9);
            v2 = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
            instr($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom, v2,
                  $urandom, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  4'($urandom_range(0, 15)), 1'($urandom), cls < 2, cls == 2, cls == 3,
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0);
            bus.id_valid = $urandom_range(0, 9) != 0;
            bus.mem_stall = $urandom_range(0, 4) == 0;
            bus.wb_reg_we = 1'($urandom);
            bus.wb_rd_idx = 5'($urandom_range(0, 5));
            bus.wb_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline.
- Consumes the decoded ALU operation and branch-inversion flag produced by the ALU decoder.
- Performs operand forwarding, the ALU operation, branch/jump resolution and load-use hazard detection.
- Holds the EX/MEM pipeline register and drives a registered PC redirect to fetch, with a shadow-kill counter for wrong-path instructions.

Parameters:
- XLEN, 32, datapath width.
- SHADOW_DEPTH, 2, number of advancing cycles whose incoming instruction is killed after a redirect.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID/EX holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_val, id_rs2_val  in  XLEN  register-file operands
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_idx, id_rs2_idx, id_rd_idx  in  5  register indices
- id_alu_control  in  4  ALUOP_* code from the ALU decoder
- id_inv_branch  in  1  branch-condition inversion from the ALU decoder
- id_is_branch, id_is_jal, id_is_jalr  in  1  control-flow class
- id_src_a_pc, id_src_b_imm  in  1  operand-A=PC / operand-B=imm selects
- id_reg_we, id_mem_re, id_mem_we  in  1  writeback/load/store intent
- mem_stall  in  1  downstream memory not ready; freeze
- wb_reg_we  in  1  WB writes the register file
- wb_rd_idx  in  5  WB destination
- wb_data  in  XLEN  WB result
- ex_valid  out  1  EX/MEM register valid
- ex_pc  out  XLEN  EX/MEM register field
- ex_result  out  XLEN  EX/MEM register field
- ex_store_data  out  XLEN  EX/MEM register field
- ex_rd_idx  out  5  EX/MEM register field
- ex_reg_we, ex_mem_re, ex_mem_we  out  1  EX/MEM register fields
- redirect_valid  out  1  registered; fetch must load redirect_pc
- redirect_pc  out  XLEN  registered redirect target
- load_use_stall  out  1  combinational; upstream holds ID/EX
- stall_out  out  1  combinational; upstream holds = mem_stall | load_use_stall

Behaviour:
- Reset (async, immediate):
  - ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, redirect_valid = 0.
  - All data outputs = 0.
  - FSM = RUN, kill counter = 0.
- Forwarding for rs1 and rs2 independently, index 0 never forwarded. Priority:
  1. EX/MEM (ex_valid & ex_reg_we & !ex_mem_re & rd match): ex_result.
  2. WB (wb_reg_we & rd match): wb_data.
  3. Register-file value.
- Operands:
  - A = id_src_a_pc ? id_pc : fwd_rs1.
  - B = id_src_b_imm ? id_imm : fwd_rs2.
  - Store data = fwd_rs2.
- ALU operations:
  - ADD and SUB: modulo 2^XLEN.
  - SLL, SRL, SRA: shift amount B[4:0]; SRA arithmetic.
  - SLT: signed; SLTU: unsigned; result 0 or 1.
  - XOR, OR, AND: bitwise.
  - Undefined code: result 0.
- Branch resolution:
  - taken = id_is_branch & ((alu_out == 0) ^ id_inv_branch).
  - Target = id_pc + id_imm.
- JAL target = alu_out. JALR target = alu_out with bit 0 cleared. Both always taken.
- ex_result = (jal|jalr) ? id_pc+4 : alu_out.
- load_use_stall = id_valid & eff_valid & ex_valid & ex_mem_re & (ex_rd_idx != 0) & (ex_rd_idx matches a used rs).
  - Effective valid (eff_valid) = id_valid & !killing.
  - A used rs is: rs1 when !id_src_a_pc; rs2 when !id_src_b_imm or id_mem_we or id_is_branch.
- Advance rules per cycle:
  - mem_stall=1: EX/MEM register, redirect register and FSM all hold. mem_stall wins over load_use_stall.
  - else load_use_stall=1: EX/MEM loads a bubble (ex_valid=0, all write enables 0). No redirect. FSM unchanged.
  - else: EX/MEM loads the instruction with ex_valid = eff_valid. Write enables are gated by eff_valid.
- Redirect:
  - redirect_valid is set for exactly one advancing cycle after an eff_valid taken branch/jump; otherwise it is 0 on advance.
  - redirect_valid holds its value while mem_stall.
- FSM:
  - RUN -> SHADOW on an issued redirect; kill counter loads SHADOW_DEPTH.
  - SHADOW: each advancing cycle kills the incoming instruction (no redirect, no writes) and decrements the counter. At 0 -> RUN.
  - A redirect issued at the SHADOW->RUN boundary cycle is not possible, because that cycle's input is killed.
- Redirect PC of a not-taken branch is never driven valid; the redirect_pc value is don't-care when redirect_valid=0.

Test Plan:
1. ADD with rs1=5, rs2=7, no hazards -> next cycle ex_valid=1, ex_result=12. Same with SRA, A=0x80000000, B=4 -> 0xF8000000.
2. Back-to-back: x3=x1+x2 (x1=1, x2=2) then x4=x3+x3 -> EX/MEM forward gives ex_result=6. A WB-only match with wb_data=9 on rs1 of the second instruction -> result uses 9.
3. Load to x5 followed by ADD using x5 -> load_use_stall=1 one cycle, bubble (ex_valid=0), then ADD proceeds with the WB-forwarded value.
4. BNE with pc=0x100, imm=0x20, rs1=3, rs2=3 -> no redirect. Same with rs2=4 -> redirect_valid=1, redirect_pc=0x120, the next 2 inputs get ex_valid=0. BGE with -1 vs 1 -> not taken.
5. JALR with rs1=0x201, imm=0, pc=0x40 -> redirect_pc=0x200, ex_result=0x44. mem_stall held for 3 cycles during redirect -> redirect_valid and outputs stable.
6. Assert rst mid-SHADOW with redirect_valid=1 -> all outputs 0 immediately. After release, the first instruction is accepted (not killed).
